// File: rtl/delta_accum_ctrl.sv
// Frame accumulator: sums COUNT signed 2-bit deltas into an 8-bit result, then holds it until it is accepted.
// Define DELTA_ACCUM_SAT_EN to saturate on overflow; otherwise the sum wraps. ovf is set in both builds.
module delta_accum_ctrl #(
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] delta,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] sum,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       ovf
);

  localparam int CW = (COUNT < 2) ? 1 : $clog2(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [7:0]    acc;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          frame_go;
  logic          xfer;
  logic [7:0]    dext;
  logic [8:0]    sum9;
  logic          add_ovf;
  logic [7:0]    acc_nxt;

  // Both operands are sign-extended to 9 bits, so a disagreement between
  // bits 8 and 7 means the 8-bit result has the wrong sign.
  always_comb begin
    dext    = {{6{delta[1]}}, delta};
    sum9    = {acc[7], acc} + {dext[7], dext};
    add_ovf = sum9[8] ^ sum9[7];
`ifdef DELTA_ACCUM_SAT_EN
    acc_nxt = add_ovf ? (acc[7] ? 8'h80 : 8'h7F) : sum9[7:0];
`else
    acc_nxt = sum9[7:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    frame_go  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          frame_go  = 1'b1;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 8'h00;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (frame_go) begin
      acc   <= 8'h00;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (xfer) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (add_ovf) ovf_q <= 1'b1;
    end
  end

  assign sum = acc;
  assign ovf = ovf_q;

endmodule
